// File: rtl/alu_exec_pipe.sv
// Two-stage pipelined ALU/execute stage with valid/ready handshakes on both sides.
// Stage 1 registers operands; the ALU result is computed on the way into stage 2.
module alu_exec_pipe #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [WIDTH-1:0] imm,
    input  logic [4:0]       ctrl_in,
    input  logic [WIDTH-1:0] mem_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             illegal,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_wr_data
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,  OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR   = 4'd4,  OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
        OP_SRA   = 4'd8,  OP_CMP = 4'd9, OP_LOAD = 4'd10, OP_STORE = 4'd11
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [3:0]       s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_store_q, s2_store_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic             carry_q, carry_d, zero_q, zero_d, negative_q, negative_d;
    logic             overflow_q, overflow_d, illegal_q, illegal_d;

    logic s2_adv, s1_adv, accept;

    logic [WIDTH-1:0]        a, b, res, flag_src;
    logic [SHW-1:0]          shamt;
    logic [WIDTH:0]          add_w, sub_w, shl_w, shr_w;
    logic signed [WIDTH:0]   sra_w;
    logic                    c, v, ill;

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_adv;
        in_ready = !s1_valid_q || s1_adv;
        accept   = in_valid && in_ready;
    end

    // Shifts use a one-bit extension so the last bit shifted out lands in the spare bit.
    always_comb begin
        a        = s1_a_q;
        b        = s1_b_q;
        shamt    = b[SHW-1:0];
        add_w    = {1'b0, a} + {1'b0, b};
        sub_w    = {1'b0, a} - {1'b0, b};
        shl_w    = {1'b0, a} << shamt;
        shr_w    = {a, 1'b0} >> shamt;
        sra_w    = $signed({a, 1'b0}) >>> shamt;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        res      = '0;
        c        = 1'b0;
        v        = 1'b0;
        ill      = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res = add_w[WIDTH-1:0];
                c   = add_w[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res = (s1_op_q == OP_CMP) ? a : sub_w[WIDTH-1:0];
                c   = sub_w[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOT:   res = ~a;
            OP_SHL: begin
                res = shl_w[WIDTH-1:0];
                c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                res = shr_w[WIDTH:1];
                c   = shr_w[0];
            end
            OP_SRA: begin
                res = sra_w[WIDTH:1];
                c   = sra_w[0];
            end
            OP_LOAD:  res = mem_rd_data;
            OP_STORE: res = a;
            default:  ill = 1'b1;
        endcase
        // CMP reports zero/negative of the difference, like SUB, while passing A through.
        flag_src = (s1_op_q == OP_CMP) ? sub_w[WIDTH-1:0] : res;
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_op_d       = s1_op_q;
        s2_valid_d    = s2_valid_q;
        s2_store_d    = s2_store_q;
        aluout_d      = aluout_q;
        mem_wr_data_d = mem_wr_data_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        negative_d    = negative_q;
        overflow_d    = overflow_q;
        illegal_d     = illegal_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = src1;
            s1_b_d     = ctrl_in[4] ? imm : src2;
            s1_op_d    = ctrl_in[3:0];
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d    = 1'b1;
            s2_store_d    = (s1_op_q == OP_STORE);
            aluout_d      = res;
            mem_wr_data_d = (s1_op_q == OP_STORE) ? b : '0;
            carry_d       = c;
            zero_d        = !ill && (flag_src == '0);
            negative_d    = !ill && flag_src[WIDTH-1];
            overflow_d    = v;
            illegal_d     = ill;
        end else if (s2_adv) begin
            s2_valid_d = 1'b0;
        end
    end

    // NOTE: datapath registers are reset too, because the outputs must read 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_op_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_store_q    <= 1'b0;
            aluout_q      <= '0;
            mem_wr_data_q <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            negative_q    <= 1'b0;
            overflow_q    <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_op_q       <= s1_op_d;
            s2_valid_q    <= s2_valid_d;
            s2_store_q    <= s2_store_d;
            aluout_q      <= aluout_d;
            mem_wr_data_q <= mem_wr_data_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            negative_q    <= negative_d;
            overflow_q    <= overflow_d;
            illegal_q     <= illegal_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign aluout      = aluout_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign negative    = negative_q;
    assign overflow    = overflow_q;
    assign illegal     = illegal_q;
    assign mem_wr_data = mem_wr_data_q;
    // A store being discarded by reset must not strobe in its final cycle.
    assign mem_wr_en   = s2_valid_q && s2_store_q && out_ready && !reset;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed testbench for alu_exec_pipe at WIDTH=8 with hand-computed expected values.
module tb_alu_exec_pipe;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] src1, src2, imm, mem_rd_data, aluout, mem_wr_data;
    logic [4:0]   ctrl_in;
    logic         carry, zero, negative, overflow, illegal, mem_wr_en;

    int n_vec = 0;
    int n_err = 0;

    logic         mon_en = 1'b0;
    logic [W-1:0] got_q[$];
    int           wr_cnt = 0;
    logic [W-1:0] last_wr = '0;
    int           hold_viol = 0;
    int           hold_cyc = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_out = '0;

    alu_exec_pipe #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .imm         (imm),
        .ctrl_in     (ctrl_in),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluout      (aluout),
        .carry       (carry),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .illegal     (illegal),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clock = ~clock;

    // Output monitor on the falling edge: handoffs, store strobes, stall stability.
    always @(negedge clock) begin
        if (prev_stall) begin
            hold_cyc++;
            if (!out_valid || aluout !== prev_out) hold_viol++;
        end
        prev_stall = out_valid && !out_ready && !reset;
        prev_out   = aluout;
        if (mon_en && out_valid && out_ready) got_q.push_back(aluout);
        if (mem_wr_en) begin
            wr_cnt++;
            last_wr = mem_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single cycle; returns just after the accepting edge.
    task automatic issue(input logic [4:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] im);
        in_valid = 1'b1;
        ctrl_in  = ctrl;
        src1     = a;
        src2     = b;
        imm      = im;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // flags packed as {carry, zero, negative, overflow, illegal}
    task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] im, input logic [W-1:0] rd,
                          input logic [W-1:0] exp_out, input logic [4:0] exp_flg);
        mem_rd_data = rd;
        issue(ctrl, a, b, im);
        check({tag, "_early"}, 32'(out_valid), 32'(1'b0));
        @(posedge clock); #1;
        check({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
        check({tag, "_out"}, 32'(aluout), 32'(exp_out));
        check({tag, "_flags"}, 32'({carry, zero, negative, overflow, illegal}), 32'(exp_flg));
        @(posedge clock); #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(1'b0));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(1'b1));
        check({tag, "_aluout"}, 32'(aluout), 32'(0));
        check({tag, "_flags"}, 32'({carry, zero, negative, overflow, illegal}), 32'(0));
        check({tag, "_wr_en"}, 32'(mem_wr_en), 32'(1'b0));
        check({tag, "_wr_data"}, 32'(mem_wr_data), 32'(0));
    endtask

    initial begin
        int n_sent;
        int hold_base;
        int wr_base;
        logic acc;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; imm = '0; ctrl_in = '0; mem_rd_data = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1 check_cleared("rst");

        // Arithmetic, compare and immediate select
        run_op("add_carry", 5'h00, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h10, 5'b10000);
        run_op("add_ovf",   5'h00, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h80, 5'b00110);
        run_op("sub_borrow",5'h01, 8'h05, 8'h07, 8'h00, 8'h00, 8'hFE, 5'b10100);
        run_op("sub_ovf",   5'h01, 8'h80, 8'h01, 8'h00, 8'h00, 8'h7F, 5'b00010);
        run_op("cmp_eq",    5'h09, 8'h33, 8'h33, 8'h00, 8'h00, 8'h33, 5'b01000);
        run_op("cmp_lt",    5'h09, 8'h01, 8'h02, 8'h00, 8'h00, 8'h01, 5'b10100);
        run_op("sub_imm",   5'h11, 8'h03, 8'h55, 8'h03, 8'h00, 8'h00, 5'b01000);
        // Logic ops
        run_op("and",       5'h02, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h30, 5'b00000);
        run_op("or_zero",   5'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 5'b01000);
        run_op("xor",       5'h04, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h5A, 5'b00000);
        run_op("not",       5'h05, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hF0, 5'b00100);
        // Shifts, including shift-by-zero
        run_op("shl1",      5'h06, 8'h81, 8'h01, 8'h00, 8'h00, 8'h02, 5'b10000);
        run_op("shl4_imm",  5'h16, 8'h1F, 8'h00, 8'h04, 8'h00, 8'hF0, 5'b10100);
        run_op("sra3",      5'h08, 8'h80, 8'h03, 8'h00, 8'h00, 8'hF0, 5'b00100);
        run_op("shr0",      5'h07, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 5'b00000);
        run_op("shr1",      5'h07, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01, 5'b10000);
        run_op("illegal13", 5'h0D, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 5'b00001);
        run_op("load",      5'h0A, 8'h11, 8'h22, 8'h00, 8'h5A, 8'h5A, 5'b00000);

        // Back-pressure: 4 ADDs, output stalled for 3 cycles after the first result
        hold_base = hold_cyc;
        mon_en = 1'b1;
        n_sent = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (n_sent < 4);
            ctrl_in   = 5'h00;
            src1      = 8'(n_sent);
            src2      = 8'h10;
            #1;
            if (cyc == 3) check("bp_in_ready_full", 32'(in_ready), 32'(1'b0));
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            if (acc) n_sent++;
        end
        in_valid = 1'b0;
        mon_en = 1'b0;
        check("bp_count", 32'(got_q.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'(8'h10 + 8'(i)));
        end
        check("bp_stall_cycles", 32'(hold_cyc - hold_base), 32'(3));
        check("bp_hold_stable", 32'(hold_viol), 32'(0));

        // Store strobe under a 2-cycle stall
        wr_base = wr_cnt;
        out_ready = 1'b0;
        issue(5'h0B, 8'h10, 8'hAB, 8'h00);
        @(posedge clock); #1;
        check("st_valid", 32'(out_valid), 32'(1'b1));
        check("st_aluout", 32'(aluout), 32'(8'h10));
        check("st_no_strobe0", 32'(mem_wr_en), 32'(1'b0));
        @(posedge clock); #1;
        check("st_no_strobe1", 32'(mem_wr_en), 32'(1'b0));
        @(posedge clock); #1;
        out_ready = 1'b1;
        #1;
        check("st_strobe", 32'(mem_wr_en), 32'(1'b1));
        check("st_wr_data", 32'(mem_wr_data), 32'(8'hAB));
        @(posedge clock); #1;
        check("st_strobe_off", 32'(mem_wr_en), 32'(1'b0));
        check("st_strobe_count", 32'(wr_cnt - wr_base), 32'(1));
        check("st_strobe_data", 32'(last_wr), 32'(8'hAB));

        // Reset with a stalled STORE in stage 2 and an ADD in stage 1
        wr_base = wr_cnt;
        out_ready = 1'b0;
        issue(5'h0B, 8'h22, 8'hCD, 8'h00);
        issue(5'h00, 8'h7F, 8'h01, 8'h00);
        check("rst2_both_full", 32'(in_ready), 32'(1'b0));
        check("rst2_wr_data_pre", 32'(mem_wr_data), 32'(8'hCD));
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst2_no_strobe_in_reset", 32'(mem_wr_en), 32'(1'b0));
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_cleared("rst2");
        run_op("post_rst_add", 5'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 5'b00000);
        check("rst2_no_strobe", 32'(wr_cnt - wr_base), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
